ff_mul_serial_256: RTL
======================

Name: ff_mul_serial_256

Overview:
- Digit-serial 256x256 unsigned multiplier. Produces the 512-bit product that feeds the secp256k1 reduction stage.
- Sits directly upstream of the reducer: tx_product drives the reducer's 512-bit input, and a one-cycle pulse derived from tx_done rising drives the reducer's reset/start.
- Uses the same start convention as the rest of the field-arithmetic cores: holding reset high loads the operands, releasing reset starts the computation, and tx_done flags a valid result.

Parameters:
- DIGIT, 16, bits of rx_b consumed per cycle. Legal values: 8, 16, 32, 64 (must divide 256).
- NDIG, 256/DIGIT, derived localparam. Number of accumulate cycles.

Ports:
- clk  input  1  single clock, rising-edge.
- reset  input  1  synchronous, active-high. Doubles as load/start.
- rx_a  input  256  multiplicand, unsigned. Sampled only while reset=1.
- rx_b  input  256  multiplier, unsigned. Sampled only while reset=1.
- tx_done  output  1  high when tx_product is valid. Sticky until the next reset.
- tx_product  output  512  rx_a*rx_b, full width, no reduction.

Behaviour:
- One clock; reset is synchronous and active-high.
- Internal state:
  - a_reg[255:0]
  - b_sh[255:0]
  - acc[511:0]
  - cnt: counter of width clog2(NDIG)+1
  - state, two states: RUN and DONE.
- Reset (any edge with reset=1; priority over everything):
  - a_reg<=rx_a, b_sh<=rx_b, acc<=0, cnt<=0, state<=RUN.
  - tx_done<=0, tx_product<=0.
  - Holding reset for multiple cycles is legal; the last sampled operands win.
- RUN, cnt<NDIG (one accumulate per edge):
  - partial = a_reg*b_sh[DIGIT-1:0], 256+DIGIT bits, unsigned.
  - acc <= acc + (partial << (DIGIT*cnt)), truncated to 512 bits. This never overflows because the final product is below 2^512.
  - b_sh <= b_sh >> DIGIT (zero fill).
  - cnt <= cnt+1.
- RUN, cnt==NDIG: tx_product<=acc, tx_done<=1, state<=DONE.
- DONE: all registers hold. rx_a and rx_b are ignored. tx_done stays 1 indefinitely.
- Latency: edge 1 is the first rising edge with reset=0. Accumulates happen on edges 1..NDIG. tx_done and tx_product are valid after edge NDIG+1 (edge 17 for DIGIT=16). Latency is fixed and independent of operand values; there is no early exit on zero digits.
- Reset mid-operation (during RUN, or in DONE): the computation is aborted immediately, tx_done drops on that same edge, and a fresh run starts with the newly sampled operands. No partial result is ever presented.
- tx_product changes only on the DONE-entry edge or on reset. It is stable whenever tx_done=1.
- Multiply implementation: a single 256xDIGIT multiplier. The shifted add may be realised as a variable shift, or as a right-shifting accumulator with equivalent results. Internal pipelining is allowed only if it keeps the stated latency exactly.
- Synthesis: no latches. cnt must not wrap, because DONE holds it.

Test Plan:
- Zero operands: reset with rx_a=0, rx_b=0x1234...(any), release -> tx_done=0 through edge 16; at edge 17 tx_done=1, tx_product=0.
- Identity: rx_a=1, rx_b=1 -> tx_product=512'h1 at edge 17. Separately, rx_a=1 with rx_b=2^256-1 -> tx_product=2^256-1, which checks that the upper 256 bits are zero.
- Max operands: rx_a=rx_b=2^256-1 -> tx_product upper 256 bits = FFFF...FFFE, lower 256 bits = 000...0001.
- Reset mid-op: start with rx_a=rx_b=2^256-1, assert reset at edge 5 with rx_a=3, rx_b=5, release -> tx_done stays 0 until 17 edges after the second release; then tx_product=15, and the first operands never appear.
- Hold after done: after done, toggle rx_a/rx_b randomly for 100 cycles with reset=0 -> tx_done=1 and tx_product unchanged throughout.
- Random/curve: rx_a=Gx, rx_b=Gy of secp256k1, plus 1000 random pairs, for each legal DIGIT value -> matches the reference-model product; latency is exactly NDIG+1 edges each run.

Source files
------------

// File: rtl/ff_mul_serial_256_if.sv
`default_nettype none
// ============================================================================
// Module      : ff_mul_serial_256_if
// Description : Operand / result bundle for the digit-serial 256x256 multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
interface ff_mul_serial_256_if;
    logic [255:0] rx_a;
    logic [255:0] rx_b;
    logic         tx_done;
    logic [511:0] tx_product;

    modport master (
        output rx_a,
        output rx_b,
        input  tx_done,
        input  tx_product
    );

    modport slave (
        input  rx_a,
        input  rx_b,
        output tx_done,
        output tx_product
    );
endinterface
`default_nettype wire

// File: rtl/ff_mul_serial_256.sv
`default_nettype none
// ============================================================================
// Module      : ff_mul_serial_256
// Description : Digit-serial 256x256 unsigned multiplier, 512-bit product.
//               Reset loads operands; releasing reset starts the run.
// Revision    : 1.0 - initial release
// ============================================================================
module ff_mul_serial_256 #(
    parameter int DIGIT = 16            // 8, 16, 32 or 64
) (
    input  wire logic           clk,
    input  wire logic           reset,
    ff_mul_serial_256_if.slave  mul_if
);

    localparam int NDIG   = 256 / DIGIT;
    localparam int CW     = $clog2(NDIG) + 1;
    localparam int C_DLOG = $clog2(DIGIT);

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        DONE = 1'b1
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [255:0]        r_a_reg;
    logic [255:0]        r_b_sh,    w_b_sh_nxt;
    logic [511:0]        r_acc,     w_acc_nxt;
    logic [CW-1:0]       r_cnt,     w_cnt_nxt;
    logic                r_done,    w_done_nxt;
    logic [511:0]        r_product, w_product_nxt;

    logic [255+DIGIT:0]  w_a_ext;
    logic [255+DIGIT:0]  w_d_ext;
    logic [255+DIGIT:0]  w_partial;
    logic [511:0]        w_partial_sh;
    logic [9:0]          w_shamt;

    // Single 256xDIGIT multiplier; the digit weight is applied as a left shift
    assign w_a_ext      = {{DIGIT{1'b0}}, r_a_reg};
    assign w_d_ext      = {256'b0, r_b_sh[DIGIT-1:0]};
    assign w_partial    = w_a_ext * w_d_ext;
    assign w_shamt      = 10'(r_cnt) << C_DLOG;
    assign w_partial_sh = {{(256-DIGIT){1'b0}}, w_partial} << w_shamt;

    always_comb begin
        w_state_nxt   = r_state;
        w_b_sh_nxt    = r_b_sh;
        w_acc_nxt     = r_acc;
        w_cnt_nxt     = r_cnt;
        w_done_nxt    = r_done;
        w_product_nxt = r_product;
        case (r_state)
            RUN: begin
                if (r_cnt < CW'(NDIG)) begin
                    w_acc_nxt  = r_acc + w_partial_sh;
                    w_b_sh_nxt = r_b_sh >> DIGIT;
                    w_cnt_nxt  = r_cnt + CW'(1);
                end else begin
                    w_product_nxt = r_acc;
                    w_done_nxt    = 1'b1;
                    w_state_nxt   = DONE;
                end
            end
            // DONE holds every register, including the counter, so it never wraps
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= RUN;
            r_a_reg   <= mul_if.rx_a;
            r_b_sh    <= mul_if.rx_b;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_done    <= 1'b0;
            r_product <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_b_sh    <= w_b_sh_nxt;
            r_acc     <= w_acc_nxt;
            r_cnt     <= w_cnt_nxt;
            r_done    <= w_done_nxt;
            r_product <= w_product_nxt;
        end
    end

    assign mul_if.tx_done    = r_done;
    assign mul_if.tx_product = r_product;

endmodule
`default_nettype wire
